// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared state encodings and defaults for the MEM-stage data responder
package dmem_responder_pkg;
    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;
    localparam int unsigned DMEM_WAIT_CYCLES_DEFAULT = 2;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM, one write or read per enabled cycle, contents not reset
//   clk in, en in (access strobe), we in (1 = write), addr in [AW], wdata in [DW], rdata out [DW] (registered)
module dmem_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata_q <= mem[addr];
        end
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data responder serving requests from on-chip RAM after WAIT_CYCLES wait states
//   clk, rst (async, active-high); req_ren/req_wen/req_addr/req_wdata from the datapath;
//   rsp_rdata (held until next read completes), stall (request outstanding), ack and addr_err (one-cycle pulses)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES_DEFAULT,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ren,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic        ack,
    output logic        addr_err
);
    localparam int unsigned CW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    dmem_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0] off, ram_rdata;
    logic wr_q, wr_d;
    logic req, err, go;
    assign req = req_ren | req_wen;
    // Below-base addresses are caught by the full-width compare, so the wrapped offset never aliases into RAM.
    assign off = addr_q - BASE_ADDR;
    assign err = (off[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (off[31:ADDR_WIDTH+2] != '0);
    assign go  = (state_q == DMEM_BUSY) && req && (cnt_q == '0);
    dmem_ram #(.AW(ADDR_WIDTH), .DW(32)) u_ram (
        .clk   (clk),
        .en    (go),
        .we    (wr_q && !err),
        .addr  (off[ADDR_WIDTH+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        ack      = 1'b0;
        addr_err = 1'b0;
        unique case (state_q)
            DMEM_IDLE: begin
                // Gated by rst so the combinational stall reads 0 while reset is held with a request present.
                stall = req && !rst;
                if (req) begin
                    state_d = DMEM_BUSY;
                    cnt_d   = CW'(WAIT_CYCLES);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wr_d    = req_wen;
                end
            end
            DMEM_BUSY: begin
                stall = 1'b1;
                if (!req) state_d = DMEM_IDLE;
                else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else state_d = DMEM_DONE;
            end
            DMEM_DONE: begin
                ack      = 1'b1;
                addr_err = err;
                rdata_d  = wr_q ? rdata_q : (err ? '0 : ram_rdata);
                state_d  = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end
    // During DONE the fresh RAM word is forwarded so it is visible in the ack cycle, then held in rdata_q.
    assign rsp_rdata = rdata_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        ren [2];
    logic        wen [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        ack [2];
    logic        err [2];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .rst(rst), .req_ren(ren[0]), .req_wen(wen[0]), .req_addr(addr[0]),
        .req_wdata(wdata[0]), .rsp_rdata(rdata[0]), .stall(stall[0]), .ack(ack[0]), .addr_err(err[0])
    );
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .req_ren(ren[1]), .req_wen(wen[1]), .req_addr(addr[1]),
        .req_wdata(wdata[1]), .rsp_rdata(rdata[1]), .stall(stall[1]), .ack(ack[1]), .addr_err(err[1])
    );

    // Drives one request, holds it until ack (or cycle budget expiry), then drops it.
    task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output int ack_cyc, output int stall_cnt, output logic [31:0] rd, output logic e);
        @(negedge clk);
        ren[d] = r; wen[d] = w; addr[d] = a; wdata[d] = wd;
        ack_cyc = -1; stall_cnt = 0; rd = 'x; e = 1'bx;
        for (int c = 0; c < 16 && ack_cyc < 0; c++) begin
            #1;
            if (stall[d]) stall_cnt++;
            if (ack[d]) begin ack_cyc = c; rd = rdata[d]; e = err[d]; end
            @(negedge clk);
        end
        ren[d] = 1'b0; wen[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin ren[d] = 0; wen[d] = 0; addr[d] = 0; wdata[d] = 0; end
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({stall[d], ack[d], err[d]} !== 3'b000) begin
                errors++; $display("FAIL reset_flags dut%0d: got %b want 000", d, {stall[d], ack[d], err[d]});
            end
            checks++;
            if (rdata[d] !== 32'h0) begin
                errors++; $display("FAIL reset_rdata dut%0d: got %h want 00000000", d, rdata[d]);
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_write();
        int ac, sc; logic [31:0] rd; logic e;
        xfer(0, 0, 1, 32'h10, 32'hDEADBEEF, ac, sc, rd, e);
        checks++; if (ac !== 4) begin errors++; $display("FAIL wr_ack_cycle: got %0d want 4", ac); end
        checks++; if (sc !== 4) begin errors++; $display("FAIL wr_stall_cycles: got %0d want 4", sc); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_addr_err: got %b want 0", e); end
    endtask

    task automatic test_read();
        int ac, sc; logic [31:0] rd; logic e;
        xfer(0, 1, 0, 32'h10, 32'h0, ac, sc, rd, e);
        checks++; if (ac !== 4) begin errors++; $display("FAIL rd_ack_cycle: got %0d want 4", ac); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", rdata[0]); end
    endtask

    task automatic test_addr_err();
        int ac, sc; logic [31:0] rd; logic e;
        xfer(0, 1, 0, 32'h13, 32'h0, ac, sc, rd, e);
        checks++; if (ac !== 4 || e !== 1'b1) begin errors++; $display("FAIL misaligned_rd_err: got ack@%0d err=%b want ack@4 err=1", ac, e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_rd_data: got %h want 00000000", rd); end
        xfer(0, 0, 1, 32'h0, 32'hA5A5A5A5, ac, sc, rd, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL word0_wr_err: got %b want 0", e); end
        xfer(0, 0, 1, 32'h1000, 32'h11111111, ac, sc, rd, e);
        checks++; if (ac !== 4 || e !== 1'b1) begin errors++; $display("FAIL range_wr_err: got ack@%0d err=%b want ack@4 err=1", ac, e); end
        xfer(0, 0, 1, 32'h11, 32'h22222222, ac, sc, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_wr_err: got %b want 1", e); end
        xfer(0, 1, 0, 32'h0, 32'h0, ac, sc, rd, e);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL range_wr_suppressed: got %h want a5a5a5a5", rd); end
        xfer(0, 1, 0, 32'h10, 32'h0, ac, sc, rd, e);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_wr_suppressed: got %h want deadbeef", rd); end
    endtask

    task automatic test_both();
        int ac, sc; logic [31:0] rd; logic e;
        xfer(0, 1, 1, 32'h20, 32'h1234, ac, sc, rd, e);
        checks++; if (ac !== 4) begin errors++; $display("FAIL both_ack_cycle: got %0d want 4", ac); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rdata_kept: got %h want deadbeef", rd); end
        xfer(0, 1, 0, 32'h20, 32'h0, ac, sc, rd, e);
        checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL both_write_done: got %h want 00001234", rd); end
    endtask

    task automatic test_reset_abort();
        int ac, sc, acks; logic [31:0] rd; logic e;
        xfer(0, 0, 1, 32'h24, 32'h5555, ac, sc, rd, e);
        checks++; if (ac !== 4) begin errors++; $display("FAIL w9_ack_cycle: got %0d want 4", ac); end
        @(negedge clk); wen[0] = 1; addr[0] = 32'h24; wdata[0] = 32'hAAAA;
        @(negedge clk); #2 rst = 1'b1; #1;
        checks++;
        if ({stall[0], ack[0], err[0]} !== 3'b000 || rdata[0] !== 32'h0) begin
            errors++; $display("FAIL midbusy_reset: got flags=%b rdata=%h want 000 00000000", {stall[0], ack[0], err[0]}, rdata[0]);
        end
        wen[0] = 0;
        @(negedge clk); rst = 1'b0;
        xfer(0, 1, 0, 32'h24, 32'h0, ac, sc, rd, e);
        checks++; if (rd !== 32'h5555) begin errors++; $display("FAIL reset_no_commit: got %h want 00005555", rd); end
        @(negedge clk); wen[0] = 1; addr[0] = 32'h24; wdata[0] = 32'h7777; #1;
        checks++; if (stall[0] !== 1'b1) begin errors++; $display("FAIL abort_stall_idle: got %b want 1", stall[0]); end
        @(negedge clk); wen[0] = 0; #1;
        checks++; if (stall[0] !== 1'b1) begin errors++; $display("FAIL abort_stall_busy: got %b want 1", stall[0]); end
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (ack[0]) acks++;
            if (c == 0) begin
                checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL abort_to_idle: got stall=%b want 0", stall[0]); end
            end
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        xfer(0, 1, 0, 32'h24, 32'h0, ac, sc, rd, e);
        checks++; if (ac !== 4 || rd !== 32'h5555) begin errors++; $display("FAIL abort_no_write: got ack@%0d %h want ack@4 00005555", ac, rd); end
    endtask

    task automatic test_back_to_back();
        int ac, sc; logic [31:0] rd, rd0, rd1; logic e;
        logic [7:0] ack_mask, stall_mask;
        xfer(1, 0, 1, 32'h0, 32'h00001111, ac, sc, rd, e);
        checks++; if (ac !== 2 || sc !== 2) begin errors++; $display("FAIL w0_latency: got ack@%0d stall=%0d want ack@2 stall=2", ac, sc); end
        xfer(1, 0, 1, 32'h4, 32'h00002222, ac, sc, rd, e);
        @(negedge clk); ren[1] = 1; addr[1] = 32'h0;
        ack_mask = '0; stall_mask = '0; rd0 = 'x; rd1 = 'x;
        for (int c = 0; c < 8; c++) begin
            #1;
            ack_mask[c] = ack[1];
            stall_mask[c] = stall[1];
            if (c == 2) rd0 = rdata[1];
            if (c == 5) rd1 = rdata[1];
            @(negedge clk);
            if (c == 2) addr[1] = 32'h4;
            if (c == 5) ren[1] = 0;
        end
        checks++; if (ack_mask !== 8'b0010_0100) begin errors++; $display("FAIL b2b_ack_cycles: got %b want 00100100", ack_mask); end
        checks++; if (stall_mask !== 8'b0001_1011) begin errors++; $display("FAIL b2b_stall_cycles: got %b want 00011011", stall_mask); end
        checks++; if (rd0 !== 32'h1111 || rd1 !== 32'h2222) begin errors++; $display("FAIL b2b_data: got %h %h want 00001111 00002222", rd0, rd1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_err();
        test_both();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
